gb_regmap_top: RTL and testbench

- Top-level register/RAM map on a 24-bit-address, 32-bit-data host bus (gb_*).
- Holds one 8-bit scratch register and an optional 4-bit "baz" register with an 8x8 RAM.
- Holds FOO_COPIES replicated slices, each a 4-bit register plus an 8x8 RAM.
- All storage is host read/write; read data returns with fixed latency.

---
 rtl/gb_regmap_pkg.sv | 61 ++++++
 rtl/gb_foo_slice.sv | 40 ++++
 rtl/gb_regmap_top.sv | 155 +++++++++++++++
 tb/tb_gb_regmap_top.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/gb_regmap_pkg.sv
// gb_regmap_pkg: address map, widths and the shared address decoder for the
// gb_* host-bus register/RAM map.
package gb_regmap_pkg;

  localparam int AW     = 24;
  localparam int DW     = 32;
  localparam int REG8_W = 8;
  localparam int REG4_W = 4;
  localparam int RAM_AW = 3;

  localparam logic [AW-1:0] ADDR_TOP_REG      = 24'h000000;
  localparam logic [AW-1:0] ADDR_TOP_BAZ      = 24'h000001;
  localparam logic [AW-1:0] ADDR_WR_CNT       = 24'h000002;
  localparam logic [AW-1:0] ADDR_FOO_N_BASE   = 24'h000004;
  localparam logic [AW-1:0] ADDR_BAZ_RAM_BASE = 24'h000008;
  localparam logic [AW-1:0] ADDR_FOO_RAM_BASE = 24'h000020;

  // Which storage element an address selects.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TOP_REG,
    SEL_BAZ_REG,
    SEL_WR_CNT,
    SEL_FOO_REG,
    SEL_BAZ_RAM,
    SEL_FOO_RAM
  } gb_sel_e;

  // Decoded address: target kind, foo slice index and RAM word offset.
  typedef struct packed {
    gb_sel_e           sel;
    logic [1:0]        idx;
    logic [RAM_AW-1:0] ram_a;
  } gb_dec_t;

  // Full 24-bit decode of the nominal map; configuration gating (absent
  // slices, absent baz, counter build option) is applied by the top.
  function automatic gb_dec_t gb_decode(input logic [AW-1:0] addr);
    gb_dec_t d;
    d.sel   = SEL_NONE;
    d.idx   = 2'd0;
    d.ram_a = addr[RAM_AW-1:0];
    if (addr == ADDR_TOP_REG) begin
      d.sel = SEL_TOP_REG;
    end else if (addr == ADDR_TOP_BAZ) begin
      d.sel = SEL_BAZ_REG;
    end else if (addr == ADDR_WR_CNT) begin
      d.sel = SEL_WR_CNT;
    end else if (addr[AW-1:2] == ADDR_FOO_N_BASE[AW-1:2]) begin
      d.sel = SEL_FOO_REG;
      d.idx = addr[1:0];
    end else if (addr[AW-1:3] == ADDR_BAZ_RAM_BASE[AW-1:3]) begin
      d.sel = SEL_BAZ_RAM;
    end else if (addr[AW-1:5] == ADDR_FOO_RAM_BASE[AW-1:5]) begin
      d.sel = SEL_FOO_RAM;
      d.idx = addr[4:3];
    end
    return d;
  endfunction

endpackage

// File: rtl/gb_foo_slice.sv
// gb_foo_slice: one 4-bit register plus one 8x8 single-port RAM with a
// registered read port. Used for each foo slice and for the baz pair.
module gb_foo_slice
  import gb_regmap_pkg::*;
(
  input  logic              gb_clk,
  input  logic              gb_rst,
  input  logic              reg_we,
  input  logic              ram_we,
  input  logic [RAM_AW-1:0] ram_addr,
  input  logic [REG8_W-1:0] wdata,
  input  logic              rd_en,
  input  logic              rd_ram,
  output logic [REG8_W-1:0] rd_data
);

  logic [REG4_W-1:0] reg_q;
  // RAM contents are not reset; they start at zero from the declaration value.
  logic [REG8_W-1:0] mem [2**RAM_AW] = '{default: '0};

  // Control register: cleared on reset, captures the low nibble on write.
  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      reg_q <= '0;
    end else if (reg_we) begin
      reg_q <= wdata[REG4_W-1:0];
    end
  end

  // RAM write plus registered read; read samples pre-write contents.
  always_ff @(posedge gb_clk) begin
    if (ram_we) begin
      mem[ram_addr] <= wdata;
    end
    if (rd_en) begin
      rd_data <= rd_ram ? mem[ram_addr] : {{(REG8_W-REG4_W){1'b0}}, reg_q};
    end
  end

endmodule

// File: rtl/gb_regmap_top.sv
// gb_regmap_top: register/RAM map on the gb_* host bus.
// Optional build macro GB_WRITE_COUNTER_EN adds a read-only write counter
// at 0x02; without it 0x02 is unmapped.
//
// Bus handshake: gb_wen and gb_rstb are single-cycle strobes with no ready;
// every strobe is accepted in the cycle it is high. A read strobe sampled at
// edge N produces gb_rdata at edge N+1, held until the next read completes.
module gb_regmap_top
  import gb_regmap_pkg::*;
#(
  parameter int FOO_COPIES = 4,
  parameter int TOP_BAZ    = 1
) (
  input  logic          gb_clk,
  input  logic          gb_rst,
  input  logic [AW-1:0] gb_addr,
  input  logic [DW-1:0] gb_wdata,
  input  logic          gb_wen,
  input  logic          gb_rstb,
  output logic [DW-1:0] gb_rdata
);

  gb_dec_t           dec;
  logic [REG8_W-1:0] top_reg;
  logic [REG8_W-1:0] baz_rd;
  logic [REG8_W-1:0] foo_rd [4];
  logic [DW-1:0]     wr_cnt;

  // Stage-1 read state.
  logic              rd_vld_q;
  gb_sel_e           rd_sel_q;
  logic [1:0]        rd_idx_q;
  logic [REG8_W-1:0] top_rd_q;
  logic [DW-1:0]     cnt_rd_q;
  logic [DW-1:0]     rd_mux;

  logic unused_wdata_hi;
  assign unused_wdata_hi = ^gb_wdata[DW-1:REG8_W];

  // Decode the bus address and knock out targets absent in this build.
  always_comb begin
    dec = gb_decode(gb_addr);
    if ((dec.sel == SEL_BAZ_REG || dec.sel == SEL_BAZ_RAM) && TOP_BAZ == 0) begin
      dec.sel = SEL_NONE;
    end
    if ((dec.sel == SEL_FOO_REG || dec.sel == SEL_FOO_RAM) &&
        int'(dec.idx) >= FOO_COPIES) begin
      dec.sel = SEL_NONE;
    end
`ifndef GB_WRITE_COUNTER_EN
    if (dec.sel == SEL_WR_CNT) begin
      dec.sel = SEL_NONE;
    end
`endif
  end

  // Scratch register at 0x00.
  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      top_reg <= '0;
    end else if (gb_wen && dec.sel == SEL_TOP_REG) begin
      top_reg <= gb_wdata[REG8_W-1:0];
    end
  end

`ifdef GB_WRITE_COUNTER_EN
  // Counts every write strobe, mapped or not; wraps naturally.
  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      wr_cnt <= '0;
    end else if (gb_wen) begin
      wr_cnt <= wr_cnt + 1'b1;
    end
  end
`else
  assign wr_cnt = '0;
`endif

  // Replicated foo slices; missing slots read as zero.
  for (genvar g = 0; g < 4; g++) begin : g_foo
    if (g < FOO_COPIES) begin : g_on
      gb_foo_slice u_slice (
        .gb_clk   (gb_clk),
        .gb_rst   (gb_rst),
        .reg_we   (gb_wen && dec.sel == SEL_FOO_REG && dec.idx == 2'(g)),
        .ram_we   (gb_wen && dec.sel == SEL_FOO_RAM && dec.idx == 2'(g)),
        .ram_addr (dec.ram_a),
        .wdata    (gb_wdata[REG8_W-1:0]),
        .rd_en    (gb_rstb),
        .rd_ram   (dec.sel == SEL_FOO_RAM),
        .rd_data  (foo_rd[g])
      );
    end else begin : g_off
      assign foo_rd[g] = '0;
    end
  end

  // Baz register and RAM share the slice primitive.
  if (TOP_BAZ != 0) begin : g_baz
    gb_foo_slice u_baz (
      .gb_clk   (gb_clk),
      .gb_rst   (gb_rst),
      .reg_we   (gb_wen && dec.sel == SEL_BAZ_REG),
      .ram_we   (gb_wen && dec.sel == SEL_BAZ_RAM),
      .ram_addr (dec.ram_a),
      .wdata    (gb_wdata[REG8_W-1:0]),
      .rd_en    (gb_rstb),
      .rd_ram   (dec.sel == SEL_BAZ_RAM),
      .rd_data  (baz_rd)
    );
  end else begin : g_no_baz
    assign baz_rd = '0;
  end

  // Stage 1: register the decode and snapshot flop-based sources pre-write.
  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      rd_vld_q <= 1'b0;
      rd_sel_q <= SEL_NONE;
      rd_idx_q <= '0;
      top_rd_q <= '0;
      cnt_rd_q <= '0;
    end else begin
      rd_vld_q <= gb_rstb;
      if (gb_rstb) begin
        rd_sel_q <= dec.sel;
        rd_idx_q <= dec.idx;
        top_rd_q <= top_reg;
        cnt_rd_q <= wr_cnt;
      end
    end
  end

  // Select the stage-1 source and zero-extend to the bus width.
  always_comb begin
    rd_mux = '0;
    case (rd_sel_q)
      SEL_TOP_REG:              rd_mux = {{(DW-REG8_W){1'b0}}, top_rd_q};
      SEL_BAZ_REG, SEL_BAZ_RAM: rd_mux = {{(DW-REG8_W){1'b0}}, baz_rd};
      SEL_FOO_REG, SEL_FOO_RAM: rd_mux = {{(DW-REG8_W){1'b0}}, foo_rd[rd_idx_q]};
      SEL_WR_CNT:               rd_mux = cnt_rd_q;
      default:                  rd_mux = '0;
    endcase
  end

  // Stage 2: update read data only when a read completes; hold otherwise.
  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      gb_rdata <= '0;
    end else if (rd_vld_q) begin
      gb_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gb_regmap_top.sv
// tb_gb_regmap_top: directed self-checking bench for gb_regmap_top with
// default parameters (FOO_COPIES=4, TOP_BAZ=1).
module tb_gb_regmap_top;

  logic        gb_clk = 1'b0;
  logic        gb_rst;
  logic [23:0] gb_addr;
  logic [31:0] gb_wdata;
  logic        gb_wen;
  logic        gb_rstb;
  logic [31:0] gb_rdata;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_mem [64];

  gb_regmap_top dut (
    .gb_clk   (gb_clk),
    .gb_rst   (gb_rst),
    .gb_addr  (gb_addr),
    .gb_wdata (gb_wdata),
    .gb_wen   (gb_wen),
    .gb_rstb  (gb_rstb),
    .gb_rdata (gb_rdata)
  );

  // Clock / reset block
  always #5 gb_clk = ~gb_clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Storage width of each location in the low 64 addresses (0 = unmapped).
  function automatic logic [31:0] width_mask(input int a);
    if (a == 0) return 32'hFF;
    if (a == 1) return 32'h0F;
    if (a >= 4 && a <= 7) return 32'h0F;
    if (a >= 8 && a <= 15) return 32'hFF;
    if (a >= 32 && a <= 63) return 32'hFF;
    return 32'h0;
  endfunction

  function automatic void model_write(input logic [23:0] a, input logic [31:0] d);
    if (a < 24'd64) exp_mem[a[5:0]] = d & width_mask(int'(a));
  endfunction

  // Driver tasks
  task automatic bus_write(input logic [23:0] a, input logic [31:0] d);
    gb_addr  = a;
    gb_wdata = d;
    gb_wen   = 1'b1;
    @(posedge gb_clk);
    #1;
    gb_wen = 1'b0;
    model_write(a, d);
  endtask

  task automatic bus_read(input logic [23:0] a, output logic [31:0] d);
    gb_addr = a;
    gb_rstb = 1'b1;
    @(posedge gb_clk);
    #1;
    gb_rstb = 1'b0;
    @(posedge gb_clk);
    #1;
    d = gb_rdata;
  endtask

  // Read every low address except the counter and compare with the model.
  task automatic check_all(input string tag);
    logic [31:0] d;
    for (int a = 0; a < 64; a++) begin
      if (a != 2) begin
        bus_read(24'(a), d);
        check_eq($sformatf("%s_%02h", tag, a), d, exp_mem[a]);
      end
    end
  endtask

  task automatic do_reset();
    gb_rst = 1'b1;
    repeat (3) @(posedge gb_clk);
    #1;
    gb_rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [23:0] bb [4];

    gb_addr = '0; gb_wdata = '0; gb_wen = 1'b0; gb_rstb = 1'b0;
    for (int a = 0; a < 64; a++) exp_mem[a] = '0;

    do_reset();
    check_eq("reset_rdata", gb_rdata, 32'h0);

    // Everything reads zero after reset, twice.
    check_all("rst_p1");
    check_all("rst_p2");
    bus_read(24'h000002, d);
    check_eq("rst_cnt", d, 32'h0);

    // Registers.
    bus_write(24'h000000, 32'hCC);
    bus_write(24'h000001, 32'h01);
    for (int i = 4; i < 8; i++) bus_write(24'(i), 32'(i));
    bus_read(24'h000000, d); check_eq("top_reg", d, 32'h000000CC);
    bus_read(24'h000006, d); check_eq("foo_n2", d, 32'h00000006);

    // RAMs.
    for (int i = 0; i < 8; i++) begin
      bus_write(24'(8 + i), 32'hE8 + 32'(i));
      bus_write(24'(32 + i), 32'hD0 + 32'(i));
      bus_write(24'(40 + i), 32'hC8 + 32'(i));
      bus_write(24'(48 + i), 32'hB0 + 32'(i));
      bus_write(24'(56 + i), 32'hA8 + 32'(i));
    end
    bus_read(24'h00000F, d); check_eq("baz_ram7", d, 32'h000000EF);
    bus_read(24'h00003C, d); check_eq("foo_ram3_4", d, 32'h000000AC);
    check_all("fill");

    // Truncation and unmapped writes.
    bus_write(24'h000004, 32'hFFFFFF5A);
    bus_read(24'h000004, d); check_eq("trunc4", d, 32'h0000000A);
    bus_write(24'h000000, 32'hFFFFFF5A);
    bus_read(24'h000000, d); check_eq("trunc8", d, 32'h0000005A);
    bus_write(24'h000040, 32'h123);
    bus_read(24'h000040, d); check_eq("unmap40", d, 32'h0);
    bus_write(24'h010000, 32'h99);
    bus_read(24'h010000, d); check_eq("unmap_hi", d, 32'h0);
`ifndef GB_WRITE_COUNTER_EN
    bus_write(24'h000002, 32'h55);
    bus_read(24'h000002, d); check_eq("unmap02", d, 32'h0);
`endif
    check_all("trunc");

    // Same-cycle write and read returns the old value.
    gb_addr = 24'h000000; gb_wdata = 32'h77; gb_wen = 1'b1; gb_rstb = 1'b1;
    @(posedge gb_clk); #1; gb_wen = 1'b0; gb_rstb = 1'b0;
    @(posedge gb_clk); #1;
    check_eq("rw_reg_old", gb_rdata, 32'h5A);
    model_write(24'h000000, 32'h77);
    gb_addr = 24'h000020; gb_wdata = 32'h11; gb_wen = 1'b1; gb_rstb = 1'b1;
    @(posedge gb_clk); #1; gb_wen = 1'b0; gb_rstb = 1'b0;
    @(posedge gb_clk); #1;
    check_eq("rw_ram_old", gb_rdata, 32'hD0);
    model_write(24'h000020, 32'h11);
    bus_read(24'h000000, d); check_eq("rw_reg_new", d, 32'h77);
    bus_read(24'h000020, d); check_eq("rw_ram_new", d, 32'h11);

    // Back-to-back reads, one per cycle.
    bb[0] = 24'h000021; bb[1] = 24'h000000; bb[2] = 24'h00003F; bb[3] = 24'h000001;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin gb_addr = bb[k]; gb_rstb = 1'b1; end
      else gb_rstb = 1'b0;
      @(posedge gb_clk); #1;
      if (k >= 1) check_eq($sformatf("b2b_%0d", k - 1), gb_rdata, exp_mem[bb[k-1][5:0]]);
    end
    repeat (5) @(posedge gb_clk);
    #1;
    check_eq("hold", gb_rdata, 32'h00000001);

    // Reset while a read is in flight discards it.
    gb_addr = 24'h000020; gb_rstb = 1'b1;
    @(posedge gb_clk); #1; gb_rstb = 1'b0; gb_rst = 1'b1;
    @(posedge gb_clk); #1;
    check_eq("rst_flight", gb_rdata, 32'h0);
    gb_rst = 1'b0;
    @(posedge gb_clk); #1;
    check_eq("rst_discard", gb_rdata, 32'h0);

    // Registers clear, RAMs keep their contents.
    exp_mem[0] = '0; exp_mem[1] = '0;
    for (int i = 4; i < 8; i++) exp_mem[i] = '0;
    check_all("post_rst");

    // Write counter: ten writes after reset, one of them to 0x02.
    do_reset();
    for (int k = 0; k < 9; k++) bus_write(24'h000040 + 24'(k), 32'(k));
    bus_write(24'h000002, 32'hDEAD);
    bus_read(24'h000002, d);
`ifdef GB_WRITE_COUNTER_EN
    check_eq("wr_cnt", d, 32'h0000000A);
`else
    check_eq("wr_cnt", d, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
